// File: rtl/grace_sched_pkg.sv
// grace_sched_pkg: shared FSM encodings and widths for the grace-period scheduler.
package grace_sched_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] REL  = 2'd2;
    localparam int GRACE_CNT_W = 4;
    localparam int MAX_EXTEND  = 3;
endpackage

// File: rtl/grace_window_ctr.sv
// grace_window_ctr: down-counting grace window; expire marks the last window cycle.
module grace_window_ctr
    import grace_sched_pkg::*;
#(
    parameter int GRACE_CYCLES = 8
) (
    input  logic clk,
    input  logic arst,
    input  logic load,
    input  logic abort,
    output logic active,
    output logic expire
);
    logic [GRACE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = abort ? '0 :
                load  ? GRACE_CNT_W'(GRACE_CYCLES) :
                (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign active = cnt_q != '0;
    assign expire = cnt_q == GRACE_CNT_W'(1);
endmodule

// File: rtl/grace_period_sched.sv
// grace_period_sched: round-robin owner of one shared grace-period timer.
// Define GRACE_SCHED_EXTEND_EN to add the extend input (up to MAX_EXTEND reloads per window).
module grace_period_sched
    import grace_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GRACE_CYCLES = 8,
    parameter int TARGET_CHIP  = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [NUM_REQ-1:0] req,
`ifdef GRACE_SCHED_EXTEND_EN
    input  logic               extend,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic               grace,
    output logic [NUM_REQ-1:0] done,
    output logic               busy
);
    localparam int OW = $clog2(NUM_REQ);

    if (GRACE_CYCLES < 1 || GRACE_CYCLES > 15 || NUM_REQ < 2 || NUM_REQ > 8 || TARGET_CHIP < 0) begin : g_bad_cfg
        $error("grace_period_sched: unsupported parameter set");
    end

    logic [1:0]         state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [OW-1:0]      win;
    logic               found;
    logic               own_req, ext_ok, load, abort, active, expire;
    logic [OW-1:0]      rr_next;

    always_comb begin
        win   = rr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[OW'((int'(rr_q) + i) % NUM_REQ)]) begin
                win   = OW'((int'(rr_q) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

`ifdef GRACE_SCHED_EXTEND_EN
    logic [1:0] ext_q, ext_d;
    assign ext_ok = extend && ext_q < 2'(MAX_EXTEND);
    always_comb begin
        ext_d = (state_q == IDLE) ? 2'd0 :
                (state_q == HOLD && ext_ok) ? ext_q + 2'd1 : ext_q;
    end
    always_ff @(posedge clk or posedge arst) begin
        if (arst) ext_q <= 2'd0;
        else      ext_q <= ext_d;
    end
`else
    assign ext_ok = 1'b0;
`endif

    assign own_req = req[owner_q];
    assign rr_next = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign load    = (state_q == IDLE && found) || (state_q == HOLD && ext_ok);
    assign abort   = state_q == HOLD && !own_req;

    grace_window_ctr #(.GRACE_CYCLES(GRACE_CYCLES)) u_ctr (
        .clk    (clk),
        .arst   (arst),
        .load   (load),
        .abort  (abort),
        .active (active),
        .expire (expire)
    );

    // Abandon wins over expiry, so a request dropped on the last cycle gets no done.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                state_d = found ? HOLD : IDLE;
                owner_d = found ? win : owner_q;
            end
            HOLD: begin
                if (!own_req) begin
                    state_d = REL;
                    rr_d    = rr_next;
                end else if (expire && !ext_ok) begin
                    state_d = REL;
                    rr_d    = rr_next;
                    done_d  = NUM_REQ'(1) << owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
        end
    end

    assign grant = (state_q == HOLD) ? NUM_REQ'(1) << owner_q : '0;
    assign grace = state_q == HOLD && active;
    assign done  = done_q;
    assign busy  = state_q != IDLE;
endmodule
